// File: rtl/matvec3_reuse_ctrl_if.sv
// Handshake and datapath-control bundle for the 3x3 matrix-vector controller.
// The master modport is the controller side; the slave modport is the upstream/datapath side.
interface matvec3_reuse_ctrl_if #(
  parameter int N    = 3,
  parameter int AW_W = $clog2(N*N),
  parameter int AW_X = $clog2(N)
);
  logic            input_valid;
  logic            input_ready;
  logic            reload_w;
  logic            output_valid;
  logic            output_ready;
  logic [AW_W-1:0] addr_w;
  logic            wr_en_w;
  logic [AW_X-1:0] addr_x;
  logic            wr_en_x;
  logic            clear_acc;
  logic            en_acc;
  logic            busy;

  modport master (
    input  input_valid, reload_w, output_ready,
    output input_ready, output_valid, addr_w, wr_en_w, addr_x, wr_en_x,
           clear_acc, en_acc, busy
  );

  modport slave (
    output input_valid, reload_w, output_ready,
    input  input_ready, output_valid, addr_w, wr_en_w, addr_x, wr_en_x,
           clear_acc, en_acc, busy
  );
endinterface

// File: rtl/matvec3_reuse_ctrl.sv
// Sequencer for the 3x3 matrix-vector datapath with optional weight reuse:
// after each job, reload_w chooses between a full W+X load or an X-only load.
module matvec3_reuse_ctrl #(
  parameter int N    = 3,
  parameter int AW_W = $clog2(N*N),
  parameter int AW_X = $clog2(N)
) (
  input logic                 clk,
  input logic                 rst,
  matvec3_reuse_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    ST_LOAD_W,
    ST_LOAD_X,
    ST_COMPUTE,
    ST_OUTPUT
  } state_e;

  state_e          state_q, state_d;
  logic [AW_W-1:0] wcnt_q, wcnt_d;
  logic [AW_X-1:0] xcnt_q, xcnt_d;
  logic [AW_X-1:0] r_q, r_d;
  logic [AW_X-1:0] k_q, k_d;

  logic            in_rdy_c;
  logic            out_vld_c;
  logic            wr_w_c;
  logic            wr_x_c;
  logic            clr_c;
  logic            en_c;
  logic            busy_c;
  logic [AW_W-1:0] aw_c;
  logic [AW_X-1:0] ax_c;
  logic [AW_W-1:0] compute_aw;

  // k is left at N-1 on entry to OUTPUT, so the same address formula holds the
  // last COMPUTE address throughout backpressure.
  assign compute_aw = AW_W'(N) * AW_W'(r_q) + AW_W'(k_q);

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    xcnt_d    = xcnt_q;
    r_d       = r_q;
    k_d       = k_q;
    in_rdy_c  = 1'b0;
    out_vld_c = 1'b0;
    wr_w_c    = 1'b0;
    wr_x_c    = 1'b0;
    clr_c     = 1'b0;
    en_c      = 1'b0;
    busy_c    = 1'b0;
    aw_c      = '0;
    ax_c      = '0;

    case (state_q)
      ST_LOAD_W: begin
        in_rdy_c = 1'b1;
        wr_w_c   = bus.input_valid;
        aw_c     = wcnt_q;
        if (bus.input_valid) begin
          if (wcnt_q == AW_W'(N*N-1)) begin
            wcnt_d  = '0;
            state_d = ST_LOAD_X;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
      end

      ST_LOAD_X: begin
        in_rdy_c = 1'b1;
        wr_x_c   = bus.input_valid;
        ax_c     = xcnt_q;
        if (bus.input_valid) begin
          if (xcnt_q == AW_X'(N-1)) begin
            xcnt_d  = '0;
            r_d     = '0;
            k_d     = '0;
            state_d = ST_COMPUTE;
          end else begin
            xcnt_d = xcnt_q + 1'b1;
          end
        end
      end

      ST_COMPUTE: begin
        busy_c = 1'b1;
        en_c   = 1'b1;
        clr_c  = (k_q == '0);
        aw_c   = compute_aw;
        ax_c   = k_q;
        if (k_q == AW_X'(N-1)) begin
          state_d = ST_OUTPUT;
        end else begin
          k_d = k_q + 1'b1;
        end
      end

      ST_OUTPUT: begin
        busy_c    = 1'b1;
        out_vld_c = 1'b1;
        aw_c      = compute_aw;
        ax_c      = k_q;
        if (bus.output_ready) begin
          if (r_q == AW_X'(N-1)) begin
            state_d = bus.reload_w ? ST_LOAD_W : ST_LOAD_X;
          end else begin
            r_d     = r_q + 1'b1;
            k_d     = '0;
            state_d = ST_COMPUTE;
          end
        end
      end

      default: state_d = ST_LOAD_W;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_LOAD_W;
      wcnt_q  <= '0;
      xcnt_q  <= '0;
      r_q     <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      xcnt_q  <= xcnt_d;
      r_q     <= r_d;
      k_q     <= k_d;
    end
  end

  assign bus.input_ready  = in_rdy_c;
  assign bus.output_valid = out_vld_c;
  assign bus.wr_en_w      = wr_w_c;
  assign bus.wr_en_x      = wr_x_c;
  assign bus.clear_acc    = clr_c;
  assign bus.en_acc       = en_c;
  assign bus.busy         = busy_c;
  assign bus.addr_w       = aw_c;
  assign bus.addr_x       = ax_c;

endmodule

// File: tb/tb_matvec3_reuse_ctrl.sv
// Self-checking bench: a job-level reference model predicts every control output each
// cycle, and a behavioural W/X RAM + accumulator checks the row results it produces.
module tb_matvec3_reuse_ctrl;

  logic clk;
  logic rst;
  logic signed [13:0] din;

  matvec3_reuse_ctrl_if #(.N(3)) bus ();

  matvec3_reuse_ctrl #(.N(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Behavioural datapath driven by the controller outputs
  int wram [16];
  int xram [4];
  int acc;

  always @(posedge clk) begin
    if (bus.wr_en_w) wram[bus.addr_w] <= int'(din);
    if (bus.wr_en_x) xram[bus.addr_x] <= int'(din);
    if (bus.en_acc)
      acc <= (bus.clear_acc ? 0 : acc) + wram[bus.addr_w] * xram[bus.addr_x];
    else if (bus.clear_acc)
      acc <= 0;
  end

  // Job-level reference: phase 0 load W, 1 load X, 2 compute, 3 present result
  int ph = 0, wc = 0, xc = 0, row = 0, term = 0;
  int mw [9];
  int mx [3];
  int res_q [$];

  always @(posedge clk) begin
    if (rst) begin
      ph = 0; wc = 0; xc = 0; row = 0; term = 0;
    end else begin
      case (ph)
        0: if (bus.input_valid) begin
          mw[wc] = int'(din);
          wc = wc + 1;
          if (wc == 9) begin wc = 0; ph = 1; end
        end
        1: if (bus.input_valid) begin
          mx[xc] = int'(din);
          xc = xc + 1;
          if (xc == 3) begin xc = 0; row = 0; term = 0; ph = 2; end
        end
        2: if (term == 2) ph = 3; else term = term + 1;
        default: if (bus.output_ready) begin
          res_q.push_back(acc);
          if (row < 2) begin row = row + 1; term = 0; ph = 2; end
          else ph = bus.reload_w ? 0 : 1;
        end
      endcase
    end
  end

  logic [12:0] e_vec, a_vec;
  int exp_sum;

  always @(negedge clk) begin
    if (chk_en) begin
      e_vec = '0;
      case (ph)
        0: e_vec = {1'b1, 1'b0, bus.input_valid, 1'b0, 1'b0, 1'b0, 1'b0, 4'(wc), 2'd0};
        1: e_vec = {1'b1, 1'b0, 1'b0, bus.input_valid, 1'b0, 1'b0, 1'b0, 4'd0, 2'(xc)};
        2: e_vec = {1'b0, 1'b0, 1'b0, 1'b0, (term == 0), 1'b1, 1'b1, 4'(3*row+term), 2'(term)};
        default: e_vec = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'(3*row+2), 2'd2};
      endcase
      a_vec = {bus.input_ready, bus.output_valid, bus.wr_en_w, bus.wr_en_x, bus.clear_acc,
               bus.en_acc, bus.busy, bus.addr_w, bus.addr_x};
      n_cmp++;
      if (a_vec !== e_vec) begin
        n_bad++;
        $display("FAIL ctrl t=%0t ph=%0d act={rdy,vld,ww,wx,clr,en,busy,aw,ax}=%b req=%b",
                 $time, ph, a_vec, e_vec);
      end
      if (ph == 3) begin
        exp_sum = 0;
        for (int k = 0; k < 3; k++) exp_sum += mw[3*row+k] * mx[k];
        n_cmp++;
        if (acc !== exp_sum) begin
          n_bad++;
          $display("FAIL row_data t=%0t row=%0d act=%0d req=%0d", $time, row, acc, exp_sum);
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s act=%0d req=%0d", nm, act, req);
    end
  endtask

  task automatic pin3(input string nm, input int a, input int b, input int c);
    int n;
    n = res_q.size();
    if (n < 3) chk({nm, "_count"}, n, 3);
    else begin
      chk({nm, "_r0"}, res_q[n-3], a);
      chk({nm, "_r1"}, res_q[n-2], b);
      chk({nm, "_r2"}, res_q[n-1], c);
    end
  endtask

  task automatic feed(input int v, input bit gaps);
    if (gaps && $urandom_range(0, 1) == 1) begin
      bus.input_valid = 1'b0;
      din = 14'($urandom);
      @(posedge clk); #1;
    end
    bus.input_valid = 1'b1;
    din = 14'(v);
    @(posedge clk); #1;
    bus.input_valid = 1'b0;
    din = 14'($urandom);
  endtask

  int wv [9];
  int xv [3];
  bit need_w = 1'b1;

  task automatic job(input bit gaps, input int bp, input bit rl_next, input bit abort);
    int start_n, cnt, hold;
    start_n = res_q.size();
    bus.reload_w = rl_next;
    if (need_w) for (int i = 0; i < 9; i++) feed(wv[i], gaps);
    for (int i = 0; i < 3; i++) feed(xv[i], gaps);
    need_w = rl_next;
    cnt = 0;
    while (!bus.output_valid && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("latency", cnt, 3);
    if (abort) begin
      bus.output_ready = 1'b1;
      cnt = 0;
      while (res_q.size() == start_n && cnt < 20) begin
        @(posedge clk); #1;
        cnt++;
      end
      chk("abort_row0_seen", res_q.size() - start_n, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_in_ready", int'(bus.input_ready), 1);
      chk("abort_out_valid", int'(bus.output_valid), 0);
      chk("abort_busy", int'(bus.busy), 0);
      chk("abort_addr_w", int'(bus.addr_w), 0);
      need_w = 1'b1;
      return;
    end
    hold = 0;
    cnt = 0;
    while (res_q.size() < start_n + 3 && cnt < 200) begin
      case (bp)
        0: bus.output_ready = 1'b1;
        1: bus.output_ready = ($urandom_range(0, 2) != 0);
        default: begin
          if (res_q.size() == start_n + 1 && bus.output_valid && hold < 5) begin
            chk("hold_data", acc, 32);
            bus.output_ready = 1'b0;
            hold++;
          end else begin
            bus.output_ready = 1'b1;
          end
        end
      endcase
      @(posedge clk); #1;
      cnt++;
    end
    if (bp == 2) chk("hold_cycles", hold, 5);
    if (res_q.size() < start_n + 3) chk("job_results", res_q.size() - start_n, 3);
    bus.output_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    din = '0;
    bus.input_valid  = 1'b0;
    bus.output_ready = 1'b1;
    bus.reload_w     = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;
    chk("rst_in_ready", int'(bus.input_ready), 1);
    chk("rst_out_valid", int'(bus.output_valid), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_addr_w", int'(bus.addr_w), 0);
    chk("rst_en_acc", int'(bus.en_acc), 0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) wv[i] = i + 1;
    xv[0] = 1; xv[1] = 2; xv[2] = 3;
    job(1'b0, 0, 1'b0, 1'b0);
    pin3("basic", 14, 32, 50);

    xv[0] = 1; xv[1] = 0; xv[2] = -1;
    job(1'b0, 0, 1'b1, 1'b0);
    pin3("reuse_w", -2, -2, -2);

    xv[0] = 1; xv[1] = 2; xv[2] = 3;
    job(1'b1, 2, 1'b0, 1'b0);
    pin3("gaps_hold", 14, 32, 50);

    job(1'b0, 0, 1'b0, 1'b1);

    for (int i = 0; i < 9; i++) wv[i] = -8192;
    for (int i = 0; i < 3; i++) xv[i] = -8192;
    job(1'b0, 1, 1'b1, 1'b0);
    pin3("extreme", 201326592, 201326592, 201326592);
    chk("reload_to_load_w", ph, 0);

    for (int j = 0; j < 16; j++) begin
      for (int i = 0; i < 9; i++) wv[i] = int'($signed(14'($urandom)));
      for (int i = 0; i < 3; i++) xv[i] = int'($signed(14'($urandom)));
      job(1'b1, 1, 1'($urandom_range(0, 1)), 1'b0);
    end

    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
